// File: rtl/majority_vote_pkg.sv
// Shared types and helpers for the majority voting FSM.
package majority_vote_pkg;

    // FSM state encoding
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StDecide  = 2'd2
    } state_e;

    // Ceiling log2, usable in constant expressions
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vote_popcount.sv
// Combinational ones-count of an N-bit vector, reported on CW bits.
module vote_popcount #(
    parameter int unsigned N  = 5,
    parameter int unsigned CW = 3
) (
    input  logic [N-1:0]  vec_i,
    output logic [CW-1:0] cnt_o
);

    // Sum every bit; CW is wide enough that the sum cannot wrap
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < int'(N); i++) begin
            cnt_o = cnt_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/majority_vote_fsm.sv
// Timed voting session: IDLE -> COLLECT -> DECIDE -> IDLE.
// Latches the first vote of each voter, closes when everyone has voted or the
// timer runs out, then publishes pass/fail and the yes count.
// Optional feature: define VOTE_VETO_EN to give voter 0 a veto (explicit no forces pass=0).
module majority_vote_fsm
    import majority_vote_pkg::*;
#(
    parameter int unsigned N       = 5,
    parameter int unsigned THRESH  = N / 2 + 1,
    parameter int unsigned TIMEOUT = 15,
    // Derived width of yes_cnt_o; leave at its default
    parameter int unsigned CW      = clog2(N + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [N-1:0]  vote_stb_i,
    input  logic [N-1:0]  vote_val_i,
    output logic          busy_o,
    output logic [N-1:0]  voted_o,
    output logic          done_o,
    output logic          pass_o,
    output logic [CW-1:0] yes_cnt_o
);

    localparam int unsigned    TW         = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0]  THRESH_C   = CW'(THRESH);

    state_e        state_q;
    logic [TW-1:0] timer_q;
    logic [N-1:0]  voted_q;
    logic [N-1:0]  val_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [CW-1:0] yes_cnt_q;

    logic [N-1:0]  voted_d;
    logic [N-1:0]  new_mask;
    logic [CW-1:0] yes_cnt_d;
    logic          pass_d;

    // Only yes values from voters that actually voted are counted
    vote_popcount #(
        .N  (N),
        .CW (CW)
    ) u_popcount (
        .vec_i (val_q & voted_q),
        .cnt_o (yes_cnt_d)
    );

    // Votes accepted on this edge and the resulting voted set / verdict
    always_comb begin
        new_mask = vote_stb_i & ~voted_q;
        voted_d  = voted_q | vote_stb_i;
        pass_d   = (yes_cnt_d >= THRESH_C);
`ifdef VOTE_VETO_EN
        // An explicit no from voter 0 overrides the majority
        if (voted_q[0] && !val_q[0]) begin
            pass_d = 1'b0;
        end
`endif
    end

    // Session FSM with timer, vote latches and registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            voted_q   <= '0;
            val_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            yes_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StCollect;
                        busy_q  <= 1'b1;
                        voted_q <= '0;
                        val_q   <= '0;
                        timer_q <= '0;
                    end
                end
                StCollect: begin
                    voted_q <= voted_d;
                    val_q   <= (val_q & ~new_mask) | (vote_val_i & new_mask);
                    timer_q <= timer_q + TW'(1);
                    if ((&voted_d) || (timer_q == TIMER_LAST)) begin
                        state_q <= StDecide;
                    end
                end
                StDecide: begin
                    yes_cnt_q <= yes_cnt_d;
                    pass_q    <= pass_d;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign voted_o   = voted_q;
    assign done_o    = done_q;
    assign pass_o    = pass_q;
    assign yes_cnt_o = yes_cnt_q;

endmodule

// File: tb/tb_majority_vote_fsm.sv
// Randomised and directed bench for majority_vote_fsm against a session-level model.
module tb_majority_vote_fsm;

    localparam int unsigned N       = 5;
    localparam int unsigned THRESH  = 3;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CW      = 3;
`ifdef VOTE_VETO_EN
    localparam bit VetoOn = 1'b1;
`else
    localparam bit VetoOn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  vote_stb = '0;
    logic [N-1:0]  vote_val = '0;
    logic          busy;
    logic [N-1:0]  voted;
    logic          done;
    logic          pass;
    logic [CW-1:0] yes_cnt;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: per-voter vote (-1 none, 0 no, 1 yes), session progress, published result
    int m_votes [N];
    bit m_busy, m_decide, m_done, m_pass;
    int m_cycles, m_cnt;

    majority_vote_fsm #(
        .N       (N),
        .THRESH  (THRESH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .vote_stb_i (vote_stb),
        .vote_val_i (vote_val),
        .busy_o     (busy),
        .voted_o    (voted),
        .done_o     (done),
        .pass_o     (pass),
        .yes_cnt_o  (yes_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_voted_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < int'(N); i++) v[i] = (m_votes[i] >= 0);
        return v;
    endfunction

    function automatic int m_yes();
        int c;
        c = 0;
        for (int i = 0; i < int'(N); i++) if (m_votes[i] == 1) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) m_votes[i] = -1;
        m_busy = 0; m_decide = 0; m_done = 0; m_pass = 0;
        m_cycles = 0; m_cnt = 0;
    endtask

    // Advance the model by one rising edge using the inputs the DUT just sampled
    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (m_decide) begin
            m_cnt    = m_yes();
            m_pass   = (m_cnt >= int'(THRESH)) && !(VetoOn && m_votes[0] == 0);
            m_done   = 1;
            m_busy   = 0;
            m_decide = 0;
        end else if (m_busy) begin
            m_done = 0;
            for (int i = 0; i < int'(N); i++)
                if (vote_stb[i] && m_votes[i] < 0) m_votes[i] = int'(vote_val[i]);
            m_cycles++;
            if (m_voted_vec() == '1 || m_cycles == int'(TIMEOUT)) m_decide = 1;
        end else begin
            m_done = 0;
            if (start) begin
                m_busy = 1;
                for (int i = 0; i < int'(N); i++) m_votes[i] = -1;
                m_cycles = 0;
            end
        end
    endtask

    // Compare DUT outputs with the model every cycle, away from the rising edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("voted", 32'(voted), 32'(m_voted_vec()));
            check("done", 32'(done), 32'(m_done));
            check("pass", 32'(pass), 32'(m_pass));
            check("yes_cnt", 32'(yes_cnt), 32'(m_cnt));
        end
    end

    // Apply one cycle of inputs; returns at the following falling edge
    task automatic step(input bit st, input logic [N-1:0] stb, input logic [N-1:0] val);
        start    = st;
        vote_stb = stb;
        vote_val = val;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0);
    endtask

    // Asynchronous reset between edges; outputs must clear at once
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_voted", 32'(voted), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_cnt", 32'(yes_cnt), 32'd0);
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_pass", 32'(pass), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: all five vote on the first COLLECT cycle
        step(1'b1, 5'b00000, 5'b00000);
        step(1'b0, 5'b11111, 5'b10110);
        check("t1_busy_decide", 32'(busy), 32'd1);
        check("t1_no_done_yet", 32'(done), 32'd0);
        step(1'b0, 5'b00000, 5'b00000);
        check("t1_done", 32'(done), 32'd1);
        check("t1_pass", 32'(pass), VetoOn ? 32'd0 : 32'd1);
        check("t1_cnt", 32'(yes_cnt), 32'd3);
        check("t1_busy", 32'(busy), 32'd0);
        idle(1);
        check("t1_done_pulse", 32'(done), 32'd0);

        // 2: three yes votes, two abstain -> timeout after 8 COLLECT cycles
        step(1'b1, 5'b00000, 5'b00000);
        step(1'b0, 5'b00001, 5'b00001);
        step(1'b0, 5'b00010, 5'b00010);
        step(1'b0, 5'b00100, 5'b00100);
        idle(5);
        check("t2_busy_at_close", 32'(busy), 32'd1);
        idle(1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_voted", 32'(voted), 32'b00111);
        check("t2_cnt", 32'(yes_cnt), 32'd3);
        check("t2_pass", 32'(pass), 32'd1);

        // 3: voter 1 yes then no; first vote wins
        step(1'b1, 5'b00000, 5'b00000);
        step(1'b0, 5'b00010, 5'b00010);
        step(1'b0, 5'b00010, 5'b00000);
        check("t3_voted1", 32'(voted[1]), 32'd1);
        step(1'b0, 5'b11101, 5'b00000);
        idle(1);
        check("t3_cnt", 32'(yes_cnt), 32'd1);
        check("t3_pass", 32'(pass), 32'd0);

        // 4: voter 4 yes on the timeout cycle
        step(1'b1, 5'b00000, 5'b00000);
        step(1'b0, 5'b00001, 5'b00001);
        step(1'b0, 5'b00010, 5'b00010);
        idle(5);
        step(1'b0, 5'b10000, 5'b10000);
        idle(1);
        check("t4_voted", 32'(voted), 32'b10011);
        check("t4_cnt", 32'(yes_cnt), 32'd3);
        check("t4_pass", 32'(pass), 32'd1);

        // 5: start while busy ignored, then async reset mid-COLLECT
        step(1'b1, 5'b00000, 5'b00000);
        step(1'b0, 5'b00001, 5'b00001);
        step(1'b1, 5'b00000, 5'b00000);
        check("t5_still_busy", 32'(voted), 32'b00001);
        pulse_reset();
        idle(TIMEOUT + 2);
        check("t5_no_done", 32'(done), 32'd0);
        check("t5_idle", 32'(busy), 32'd0);

        // 6: voter 0 votes no, the rest yes
        step(1'b1, 5'b00000, 5'b00000);
        step(1'b0, 5'b11111, 5'b11110);
        idle(1);
        check("t6_cnt", 32'(yes_cnt), 32'd4);
        check("t6_pass", 32'(pass), VetoOn ? 32'd0 : 32'd1);

        // Random sessions with sparse strobes so both close paths occur
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 2) == 0,
                     N'($urandom & $urandom & $urandom),
                     N'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
